// File: rtl/dac_cfg_pkg.sv
// dac_cfg_pkg: shared types and constants for the
// DAC configuration AXI4-Lite sequencer.
package dac_cfg_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_REQ  = 3'd1,
      S_WR_RESP = 3'd2,
      S_RD_REQ  = 3'd3,
      S_RD_RESP = 3'd4,
      S_DONE    = 3'd5,
      S_ERROR   = 3'd6
   } state_t;

   // Reported error causes
   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_RESP     = 2'd1,
      ERR_MISMATCH = 2'd2,
      ERR_TIMEOUT  = 2'd3
   } err_code_t;

   localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

   // True in states that wait on a bus handshake
   function automatic logic is_wait(input state_t s);
      return (s == S_WR_REQ)  ||
             (s == S_WR_RESP) ||
             (s == S_RD_REQ)  ||
             (s == S_RD_RESP);
   endfunction

endpackage

// File: rtl/dac_cfg_wdog.sv
// dac_cfg_wdog: saturating handshake watchdog.
// expired_o is high while enabled at the limit.
module dac_cfg_wdog
   import dac_cfg_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int CW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
   input  logic          aclk,
   input  logic          areset,
   input  logic          clr_i,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          en_i,
   output logic          expired_o
);

   localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, then load, then count up
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != LIM)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && (cnt_q == LIM);

endmodule

// File: rtl/dac_cfg_sequencer.sv
// dac_cfg_sequencer: AXI4-Lite master that writes a
// block of DAC config registers and optionally reads back.
module dac_cfg_sequencer
   import dac_cfg_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   // Only a 32-bit data bus is supported
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int NUM_REGS           = 4,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0]
                 BASE_ADDR          = '0,
   parameter bit VERIFY             = 1'b1,
   parameter int TIMEOUT_CYCLES     = 1024
) (
   input  logic                   aclk,
   input  logic                   areset,

   input  logic                   start,
   input  logic [NUM_REGS*32-1:0] cfg_data,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [1:0]             err_code,
   output logic [$clog2(NUM_REGS):0] err_index,

   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [2:0]             m_axi_awprot,
   output logic                   m_axi_awvalid,
   input  logic                   m_axi_awready,

   output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                   m_axi_wvalid,
   input  logic                   m_axi_wready,

   input  logic [1:0]             m_axi_bresp,
   input  logic                   m_axi_bvalid,
   output logic                   m_axi_bready,

   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]             m_axi_arprot,
   output logic                   m_axi_arvalid,
   input  logic                   m_axi_arready,

   input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]             m_axi_rresp,
   input  logic                   m_axi_rvalid,
   output logic                   m_axi_rready
);

   localparam int IW = $clog2(NUM_REGS) + 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);
   localparam int WDW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t                 state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [NUM_REGS*32-1:0] cfg_q, cfg_d;
   logic                   aw_done_q, aw_done_d;
   logic                   w_done_q, w_done_d;
   logic                   ar_done_q, ar_done_d;
   logic                   tmo_q, tmo_d;
   logic                   error_q, error_d;
   err_code_t              code_q, code_d;
   logic [IW-1:0]          eidx_q, eidx_d;

   logic                   waiting;
   logic                   wd_clr;
   logic                   wd_exp;
   logic [31:0]            word;
   logic [C_M_AXI_ADDR_WIDTH-1:0] addr;

   assign waiting = is_wait(state_q);
   assign word    = cfg_q[32*idx_q +: 32];
   assign addr    = BASE_ADDR +
                    (C_M_AXI_ADDR_WIDTH'(idx_q) << 2);

   assign m_axi_awaddr  = addr;
   assign m_axi_awprot  = AXI_PROT_DEFAULT;
   assign m_axi_awvalid = (state_q == S_WR_REQ) && !aw_done_q;
   assign m_axi_wdata   = word;
   assign m_axi_wstrb   = '1;
   assign m_axi_wvalid  = (state_q == S_WR_REQ) && !w_done_q;
   assign m_axi_bready  = (state_q == S_WR_RESP);
   assign m_axi_araddr  = addr;
   assign m_axi_arprot  = AXI_PROT_DEFAULT;
   assign m_axi_arvalid = (state_q == S_RD_REQ) && !ar_done_q;
   assign m_axi_rready  = (state_q == S_RD_RESP);

   assign busy      = waiting;
   assign done      = (state_q == S_DONE);
   assign error     = error_q;
   assign err_code  = code_q;
   assign err_index = eidx_q;

   // Watchdog restarts every time the FSM changes state
   assign wd_clr = (state_d != state_q);

   dac_cfg_wdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wdog (
      .aclk       (aclk),
      .areset     (areset),
      .clr_i      (wd_clr),
      .load_i     (1'b0),
      .load_val_i ({WDW{1'b0}}),
      .en_i       (waiting),
      .expired_o  (wd_exp)
   );

   // Next-state, index, latch and error logic
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cfg_d     = cfg_q;
      tmo_d     = tmo_q;
      error_d   = error_q;
      code_d    = code_q;
      eidx_d    = eidx_q;
      aw_done_d = aw_done_q |
                  (m_axi_awvalid & m_axi_awready);
      w_done_d  = w_done_q |
                  (m_axi_wvalid & m_axi_wready);
      ar_done_d = ar_done_q |
                  (m_axi_arvalid & m_axi_arready);

      // After a timeout the FSM holds its state for good;
      // only handshake tracking continues so valids drop
      // correctly if the slave answers late.
      if (!tmo_q) begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  cfg_d   = cfg_data;
                  idx_d   = '0;
                  error_d = 1'b0;
                  code_d  = ERR_NONE;
                  eidx_d  = '0;
                  state_d = S_WR_REQ;
               end
            end
            S_WR_REQ: begin
               if (aw_done_d && w_done_d) begin
                  state_d = S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (m_axi_bvalid) begin
                  if (m_axi_bresp != AXI_RESP_OKAY) begin
                     error_d = 1'b1;
                     code_d  = ERR_RESP;
                     eidx_d  = idx_q;
                     state_d = S_ERROR;
                  end else if (idx_q == LAST) begin
                     if (VERIFY) begin
                        idx_d   = '0;
                        state_d = S_RD_REQ;
                     end else begin
                        state_d = S_DONE;
                     end
                  end else begin
                     idx_d   = idx_q + IW'(1);
                     state_d = S_WR_REQ;
                  end
               end
            end
            S_RD_REQ: begin
               if (ar_done_d) begin
                  state_d = S_RD_RESP;
               end
            end
            S_RD_RESP: begin
               if (m_axi_rvalid) begin
                  if (m_axi_rresp != AXI_RESP_OKAY) begin
                     error_d = 1'b1;
                     code_d  = ERR_RESP;
                     eidx_d  = idx_q;
                     state_d = S_ERROR;
                  end else if (m_axi_rdata != word) begin
                     error_d = 1'b1;
                     code_d  = ERR_MISMATCH;
                     eidx_d  = idx_q;
                     state_d = S_ERROR;
                  end else if (idx_q == LAST) begin
                     state_d = S_DONE;
                  end else begin
                     idx_d   = idx_q + IW'(1);
                     state_d = S_RD_REQ;
                  end
               end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase

         if (waiting && wd_exp && (state_d == state_q)) begin
            tmo_d   = 1'b1;
            error_d = 1'b1;
            code_d  = ERR_TIMEOUT;
            eidx_d  = idx_q;
         end
      end

      // Every request state starts with fresh handshakes
      if (state_d != state_q) begin
         aw_done_d = 1'b0;
         w_done_d  = 1'b0;
         ar_done_d = 1'b0;
      end
   end

   // State and datapath registers
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         cfg_q     <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         ar_done_q <= 1'b0;
         tmo_q     <= 1'b0;
         error_q   <= 1'b0;
         code_q    <= ERR_NONE;
         eidx_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cfg_q     <= cfg_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         ar_done_q <= ar_done_d;
         tmo_q     <= tmo_d;
         error_q   <= error_d;
         code_q    <= code_d;
         eidx_q    <= eidx_d;
      end
   end

endmodule
